ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/ram_arbiter_if.sv | 25 ++
 rtl/ram_arbiter_rr_pick2.sv | 13 +
 rtl/ram_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Prefixed so the literals do not collide with ramstate_t::BUSY.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: per-port request, lock, address, data and stall.
interface ram_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import cpu_types_pkg::*;

    logic [NREQ-1:0] req_ren;
    logic [NREQ-1:0] req_wen;
    logic [NREQ-1:0] req_lock;
    logic [NREQ-1:0] req_wait;
    word_t           req_addr  [NREQ];
    word_t           req_store [NREQ];
    word_t           req_load  [NREQ];

    modport master (
        output req_ren, req_wen, req_lock, req_addr, req_store,
        input  req_wait, req_load
    );

    modport slave (
        input  req_ren, req_wen, req_lock, req_addr, req_store,
        output req_wait, req_load
    );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the side not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);

    always_comb begin
        if (&req) pick = ~last;
        else      pick = req[1];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-RAM arbiter for two instruction and two data ports, with starvation
// escalation for instruction ports and bounded locked bursts.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned LOCK_MAX   = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus,
    output logic          ramREN,
    output logic          ramWEN,
    output word_t         ramaddr,
    output word_t         ramstore,
    input  word_t         ramload,
    input  ramstate_t     ramstate,
    output logic          grant_valid,
    output logic [1:0]    grant_id
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned BW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    localparam logic [BW-1:0] LMAX = BW'(LOCK_MAX);

    arb_state_t          state_q, state_d;
    logic [1:0]          gid_q, gid_d;
    logic [BW-1:0]       burst_q, burst_d, burst_inc;
    logic [1:0][SW-1:0]  starve_q, starve_d;
    logic                rr_d_q, rr_d_d, rr_i_q, rr_i_d;
    logic [NREQ-1:0]     act;
    logic [1:0]          starved;
    logic                d_pick, i_pick;
    logic [1:0]          win;
    logic                rel;

    assign act = bus.req_ren | bus.req_wen;

    rr_pick2 u_rr_data (.req(act[3:2]), .last(rr_d_q), .pick(d_pick));
    rr_pick2 u_rr_inst (.req(act[1:0]), .last(rr_i_q), .pick(i_pick));

    always_comb begin
        for (int unsigned i = 0; i < 2; i++)
            starved[i] = act[i] && (starve_q[i] >= SMAX);
        if (starved[0])      win = 2'd0;
        else if (starved[1]) win = 2'd1;
        else if (|act[3:2])  win = {1'b1, d_pick};
        else                 win = {1'b0, i_pick};
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state_q  <= ARB_IDLE;
            gid_q    <= '0;
            burst_q  <= '0;
            starve_q <= '0;
            rr_d_q   <= 1'b0;
            rr_i_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gid_q    <= gid_d;
            burst_q  <= burst_d;
            starve_q <= starve_d;
            rr_d_q   <= rr_d_d;
            rr_i_q   <= rr_i_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gid_d     = gid_q;
        burst_d   = burst_q;
        starve_d  = starve_q;
        rr_d_d    = rr_d_q;
        rr_i_d    = rr_i_q;
        rel       = 1'b0;
        burst_inc = burst_q + BW'(1);
        case (state_q)
            ARB_IDLE: begin
                if (|act) begin
                    state_d = ARB_BUSY;
                    gid_d   = win;
                    burst_d = '0;
                    for (int unsigned i = 0; i < 2; i++) begin
                        if (win == 2'(i))
                            starve_d[i] = '0;
                        else if (act[i] && (starve_q[i] < SMAX))
                            starve_d[i] = starve_q[i] + SW'(1);
                    end
                end
            end
            ARB_BUSY: begin
                // An abort takes precedence over a coincident ACCESS.
                if (!act[gid_q]) begin
                    rel = 1'b1;
                end else if (ramstate == ACCESS) begin
                    burst_d = burst_inc;
                    if (!(bus.req_lock[gid_q] && (burst_inc < LMAX))) rel = 1'b1;
                end
                if (rel) begin
                    state_d = ARB_IDLE;
                    if (gid_q[1]) rr_d_d = gid_q[0];
                    else          rr_i_d = gid_q[0];
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.req_wait = '1;
        for (int unsigned p = 0; p < NREQ; p++) bus.req_load[p] = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        if (state_q == ARB_BUSY) begin
            grant_valid          = 1'b1;
            grant_id             = gid_q;
            ramWEN               = bus.req_wen[gid_q];
            ramREN               = bus.req_ren[gid_q] & ~bus.req_wen[gid_q];
            ramaddr              = bus.req_addr[gid_q];
            ramstore             = bus.req_store[gid_q];
            bus.req_load[gid_q]  = ramload;
            if (act[gid_q] && (ramstate == ACCESS)) bus.req_wait[gid_q] = 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// compared against a port-level reference model of the arbitration rules.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ       = 4;
    localparam int STARVE_MAX = 8;
    localparam int LOCK_MAX   = 4;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ramREN, ramWEN, grant_valid;
    logic [1:0] grant_id;
    word_t      ramaddr, ramstore, ramload;
    ramstate_t  ramstate;

    int errors = 0;
    int checks = 0;

    ram_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_arbiter #(.NREQ(NREQ), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 CLK = ~CLK;

    // Reference model: owner port (-1 when free), words done, per-port starvation
    // and the port number last served in each class.
    int m_owner, m_words, m_last_d, m_last_i;
    int m_starve [2];
    bit         e_gv;
    int         e_gid;
    logic [3:0] e_wait;
    bit         e_ren, e_wen;
    word_t      e_addr, e_store;

    function automatic logic [3:0] want();
        return bus.req_ren | bus.req_wen;
    endfunction

    function automatic int choose(logic [3:0] w);
        for (int p = 0; p < 2; p++)
            if (w[p] && m_starve[p] >= STARVE_MAX) return p;
        if (w[2] && w[3]) return (m_last_d == 2) ? 3 : 2;
        if (w[2]) return 2;
        if (w[3]) return 3;
        if (w[0] && w[1]) return (m_last_i == 0) ? 1 : 0;
        return w[0] ? 0 : 1;
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_words = 0; m_last_d = 2; m_last_i = 0;
        m_starve[0] = 0; m_starve[1] = 0;
    endfunction

    function automatic void model_expect();
        logic [3:0] w = want();
        e_gv = 0; e_gid = 0; e_wait = '1; e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
        if (m_owner >= 0) begin
            e_gv    = 1;
            e_gid   = m_owner;
            e_wen   = bus.req_wen[m_owner];
            e_ren   = bus.req_ren[m_owner] && !e_wen;
            e_addr  = bus.req_addr[m_owner];
            e_store = bus.req_store[m_owner];
            if (w[m_owner] && ramstate == ACCESS) e_wait[m_owner] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        logic [3:0] w = want();
        bit done = 0;
        int g;
        if (m_owner < 0) begin
            if (w != 0) begin
                g = choose(w);
                for (int p = 0; p < 2; p++) begin
                    if (p == g) m_starve[p] = 0;
                    else if (w[p]) m_starve[p] = (m_starve[p] + 1 > STARVE_MAX) ? STARVE_MAX : m_starve[p] + 1;
                end
                m_owner = g;
                m_words = 0;
            end
        end else begin
            if (!w[m_owner]) done = 1;
            else if (ramstate == ACCESS) begin
                m_words++;
                if (!(bus.req_lock[m_owner] && m_words < LOCK_MAX)) done = 1;
            end
            if (done) begin
                if (m_owner >= 2) m_last_d = m_owner; else m_last_i = m_owner;
                m_owner = -1;
            end
        end
    endfunction

    task automatic sample();
        @(negedge CLK);
        model_expect();
    endtask

    task automatic advance();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_ren = '0; bus.req_wen = '0; bus.req_lock = '0;
        for (int p = 0; p < NREQ; p++) begin
            bus.req_addr[p] = '0; bus.req_store[p] = '0;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; clear_inputs(); ramstate = FREE; ramload = '0;
        #2;
        checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got=%b/%0d want=0/0", grant_valid, grant_id); end
        checks++; if (bus.req_wait !== 4'hF) begin errors++; $display("FAIL rst_wait got=%b want=1111", bus.req_wait); end
        checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL rst_strobe got=%b want=00", {ramREN, ramWEN}); end
        checks++; if ({ramaddr, ramstore} !== 64'd0) begin errors++; $display("FAIL rst_bus got=%h/%h want=0/0", ramaddr, ramstore); end
        for (int p = 0; p < NREQ; p++) begin
            checks++; if (bus.req_load[p] !== 32'd0) begin errors++; $display("FAIL rst_load%0d got=%h want=0", p, bus.req_load[p]); end
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic test_single_read();
        word_t rd;
        clear_inputs(); bus.req_ren[2] = 1'b1; bus.req_addr[2] = 32'h40; ramstate = FREE;
        sample();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rd_c0_grant got=%b want=0", grant_valid); end
        advance();
        for (int c = 1; c <= 2; c++) begin
            ramstate = BUSY;
            sample();
            checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL rd_c%0d_grant got=%b/%0d want=1/2", c, grant_valid, grant_id); end
            checks++; if (bus.req_wait !== 4'hF) begin errors++; $display("FAIL rd_c%0d_wait got=%b want=1111", c, bus.req_wait); end
            checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin errors++; $display("FAIL rd_c%0d_ram got=%b%b/%h want=10/40", c, ramREN, ramWEN, ramaddr); end
            advance();
        end
        ramstate = ACCESS; rd = $urandom; ramload = rd;
        sample();
        checks++; if (bus.req_wait !== 4'b1011) begin errors++; $display("FAIL rd_c3_wait got=%b want=1011", bus.req_wait); end
        checks++; if (bus.req_load[2] !== rd) begin errors++; $display("FAIL rd_c3_load got=%h want=%h", bus.req_load[2], rd); end
        checks++; if (bus.req_load[3] !== 32'd0) begin errors++; $display("FAIL rd_c3_other_load got=%h want=0", bus.req_load[3]); end
        advance();
        clear_inputs(); ramstate = FREE;
        sample();
        checks++; if (grant_valid !== 1'b0 || bus.req_wait !== 4'hF) begin errors++; $display("FAIL rd_c4_idle got=%b/%b want=0/1111", grant_valid, bus.req_wait); end
        advance();
    endtask

    task automatic test_write_priority();
        clear_inputs(); ramstate = FREE;
        bus.req_ren[1] = 1'b1; bus.req_wen[1] = 1'b1;
        bus.req_addr[1] = 32'h10; bus.req_store[1] = 32'hDEADBEEF;
        sample(); advance();
        ramstate = BUSY;
        sample();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL wr_grant got=%b/%0d want=1/1", grant_valid, grant_id); end
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL wr_strobe got=WEN%b REN%b want=WEN1 REN0", ramWEN, ramREN); end
        checks++; if (ramstore !== 32'hDEADBEEF || ramaddr !== 32'h10) begin errors++; $display("FAIL wr_bus got=%h/%h want=deadbeef/10", ramstore, ramaddr); end
        advance();
        ramstate = ACCESS;
        sample();
        checks++; if (bus.req_wait !== 4'b1101) begin errors++; $display("FAIL wr_wait got=%b want=1101", bus.req_wait); end
        advance();
        clear_inputs(); ramstate = FREE;
        sample(); advance();
    endtask

    task automatic test_abort();
        clear_inputs(); ramstate = FREE;
        bus.req_ren[0] = 1'b1; bus.req_addr[0] = $urandom;
        sample(); advance();
        ramstate = BUSY;
        sample();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL ab_grant got=%b/%0d want=1/0", grant_valid, grant_id); end
        advance();
        bus.req_ren[0] = 1'b0; ramstate = FREE;
        sample();
        checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL ab_strobe got=%b want=00", {ramREN, ramWEN}); end
        checks++; if (bus.req_wait !== 4'hF) begin errors++; $display("FAIL ab_wait got=%b want=1111", bus.req_wait); end
        advance();
        sample();
        checks++; if (grant_valid !== 1'b0 || bus.req_wait !== 4'hF) begin errors++; $display("FAIL ab_idle got=%b/%b want=0/1111", grant_valid, bus.req_wait); end
        advance();
    endtask

    task automatic test_lock_burst();
        int left3 = 6, done3 = 0, next_gid = -1;
        bit seen_idle = 0;
        clear_inputs(); ramstate = ACCESS;
        bus.req_ren[3] = 1'b1; bus.req_lock[3] = 1'b1; bus.req_addr[3] = $urandom;
        sample(); advance();
        bus.req_ren[2] = 1'b1; bus.req_addr[2] = $urandom;
        for (int c = 0; c < 30 && next_gid < 0; c++) begin
            sample();
            if (grant_valid === 1'b1 && grant_id === 2'd3 && bus.req_wait[3] === 1'b0) begin
                done3++; left3--;
            end else if (grant_valid === 1'b0 && done3 > 0) begin
                seen_idle = 1;
            end else if (grant_valid === 1'b1 && grant_id !== 2'd3 && seen_idle) begin
                next_gid = int'(grant_id);
            end
            advance();
            if (left3 == 0) begin bus.req_ren[3] = 1'b0; bus.req_lock[3] = 1'b0; end
        end
        checks++; if (done3 != LOCK_MAX) begin errors++; $display("FAIL lock_words got=%0d want=%0d", done3, LOCK_MAX); end
        checks++; if (next_gid != 2) begin errors++; $display("FAIL lock_next_grant got=%0d want=2", next_gid); end
        clear_inputs(); ramstate = FREE;
        for (int c = 0; c < 2; c++) begin sample(); advance(); end
    endtask

    task automatic test_starve();
        int seq[$];
        bit prev_gv = 0;
        int got;
        clear_inputs(); ramstate = ACCESS;
        bus.req_ren[0] = 1'b1; bus.req_ren[1] = 1'b1; bus.req_ren[2] = 1'b1;
        sample(); advance();
        bus.req_ren[3] = 1'b1;
        for (int c = 0; c < 60 && seq.size() < 10; c++) begin
            sample();
            if (grant_valid === 1'b1 && !prev_gv) seq.push_back(int'(grant_id));
            prev_gv = (grant_valid === 1'b1);
            advance();
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < seq.size()) ? seq[i] : -1;
            checks++; if (got != ((i % 2 == 0) ? 2 : 3)) begin errors++; $display("FAIL starve_rr%0d got=%0d want=%0d", i, got, (i % 2 == 0) ? 2 : 3); end
        end
        got = (seq.size() > 8) ? seq[8] : -1;
        checks++; if (got != 0) begin errors++; $display("FAIL starve_port0 got=%0d want=0", got); end
        got = (seq.size() > 9) ? seq[9] : -1;
        checks++; if (got != 1) begin errors++; $display("FAIL starve_port1 got=%0d want=1", got); end
        clear_inputs(); ramstate = FREE;
        for (int c = 0; c < 2; c++) begin sample(); advance(); end
    endtask

    task automatic test_random();
        bit    ok;
        word_t want_load;
        clear_inputs();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NREQ; p++) begin
                if ($urandom_range(0, 4) == 0) begin
                    bus.req_ren[p]   = ($urandom_range(0, 9) < 6);
                    bus.req_wen[p]   = ($urandom_range(0, 9) < 3);
                    bus.req_lock[p]  = ($urandom_range(0, 9) < 4);
                    bus.req_addr[p]  = $urandom;
                    bus.req_store[p] = $urandom;
                end
            end
            ramstate = ramstate_t'($urandom_range(0, 3));
            ramload  = $urandom;
            sample();
            checks++; if ({grant_valid, grant_id} !== {e_gv, 2'(e_gid)}) begin errors++; $display("FAIL rnd_grant c=%0d got=%b/%0d want=%b/%0d", c, grant_valid, grant_id, e_gv, e_gid); end
            checks++; if (bus.req_wait !== e_wait) begin errors++; $display("FAIL rnd_wait c=%0d got=%b want=%b", c, bus.req_wait, e_wait); end
            checks++; if ({ramREN, ramWEN} !== {e_ren, e_wen}) begin errors++; $display("FAIL rnd_strobe c=%0d got=%b want=%b", c, {ramREN, ramWEN}, {e_ren, e_wen}); end
            checks++; if ({ramaddr, ramstore} !== {e_addr, e_store}) begin errors++; $display("FAIL rnd_bus c=%0d got=%h/%h want=%h/%h", c, ramaddr, ramstore, e_addr, e_store); end
            ok = 1;
            for (int p = 0; p < NREQ; p++) begin
                want_load = (e_gv && e_gid == p) ? ramload : 32'd0;
                if (bus.req_load[p] !== want_load) ok = 0;
            end
            checks++; if (!ok) begin errors++; $display("FAIL rnd_load c=%0d got=%h/%h/%h/%h owner=%0d want ramload=%h", c, bus.req_load[0], bus.req_load[1], bus.req_load[2], bus.req_load[3], e_gv ? e_gid : -1, ramload); end
            advance();
        end
        clear_inputs(); ramstate = FREE;
        for (int c = 0; c < 8; c++) begin sample(); advance(); end
    endtask

    task automatic test_reset_busy();
        clear_inputs(); ramstate = BUSY;
        bus.req_wen[2] = 1'b1; bus.req_addr[2] = $urandom; bus.req_store[2] = $urandom;
        sample(); advance();
        sample();
        checks++; if (ramWEN !== 1'b1) begin errors++; $display("FAIL rb_pre_wen got=%b want=1", ramWEN); end
        ramstate = ACCESS; nRST = 1'b0;
        #1;
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rb_wen got=%b want=0", ramWEN); end
        checks++; if (bus.req_wait !== 4'hF || grant_valid !== 1'b0) begin errors++; $display("FAIL rb_wait got=%b/%b want=1111/0", bus.req_wait, grant_valid); end
        @(posedge CLK); #1;
        checks++; if (bus.req_wait !== 4'hF) begin errors++; $display("FAIL rb_no_pulse got=%b want=1111", bus.req_wait); end
        nRST = 1'b1;
        model_reset();
        clear_inputs(); ramstate = FREE;
        bus.req_ren[2] = 1'b1; bus.req_ren[3] = 1'b1;
        sample(); advance();
        sample();
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'(e_gid)) begin errors++; $display("FAIL rb_first_grant got=%b/%0d want=1/%0d", grant_valid, grant_id, e_gid); end
        advance();
        clear_inputs();
        for (int c = 0; c < 2; c++) begin sample(); advance(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_priority();
        test_abort();
        test_lock_burst();
        test_starve();
        test_random();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
